// File: rtl/rename_freelist_ctrl.sv
// Physical register free-list for the rename stage: up to two grants and two
// frees per cycle, committed read pointer for one-cycle restart rollback.
//
// Ports:
//   iCLOCK, iRESET          clock, synchronous active-high reset
//   iRESTART_VALID          flush: speculative allocations return to the list
//   iALLOC_{0,1}_REQ        rename slots requesting a preg
//   oALLOC_VALID            all-or-nothing grant (same cycle)
//   oALLOC_{0,1}_REGNAME    pregs offered to slot 0/1
//   iCOMMIT_{0,1}_VALID     oldest/second-oldest allocation retired
//   iFREE_{0,1}_VALID/NAME  old pregs returned to the list
//   oLOCK                   rename stall (list not running or < 2 free)
//   oFREE_COUNT             speculative free entries
//   oINIT_BUSY              list being filled after reset
//   oERROR                  sticky protocol error
// Optional macro RENAME_FREELIST_CHECK_EN adds the protocol checker;
// without it oERROR is tied low.

module rename_freelist_ctrl #(
  parameter int PREG_NUM = 64,
  parameter int LREG_NUM = 32
) (
  input  logic       iCLOCK,
  input  logic       iRESET,
  input  logic       iRESTART_VALID,
  input  logic       iALLOC_0_REQ,
  input  logic       iALLOC_1_REQ,
  output logic       oALLOC_VALID,
  output logic [5:0] oALLOC_0_REGNAME,
  output logic [5:0] oALLOC_1_REGNAME,
  input  logic       iCOMMIT_0_VALID,
  input  logic       iCOMMIT_1_VALID,
  input  logic       iFREE_0_VALID,
  input  logic [5:0] iFREE_0_REGNAME,
  input  logic       iFREE_1_VALID,
  input  logic [5:0] iFREE_1_REGNAME,
  output logic       oLOCK,
  output logic [5:0] oFREE_COUNT,
  output logic       oINIT_BUSY,
  output logic       oERROR
);

  localparam int D  = PREG_NUM - LREG_NUM;
  localparam int PW = $clog2(D);
  localparam int CW = PW + 1;

  typedef enum logic {
    INIT,
    RUN
  } state_t;

  state_t state;
  state_t stateNext;

  logic [5:0]    mem [D];
  logic [PW-1:0] rdSpec;
  logic [PW-1:0] rdCmt;
  logic [PW-1:0] wr;
  logic [PW-1:0] initCnt;
  logic [CW-1:0] specCnt;
  logic [CW-1:0] cmtCnt;

  logic          run;
  logic          grant;
  logic [1:0]    allocNum;
  logic [1:0]    cmtReq;
  logic [1:0]    freeReq;
  logic [1:0]    cmtNum;
  logic [1:0]    freeNum;
  logic [PW-1:0] rdSpecP1;
  logic [PW-1:0] wrP1;
  logic [5:0]    firstName;
  logic [5:0]    secondName;
  logic          initLast;

  assign run      = (state == RUN);
  assign initLast = (initCnt == PW'(D - 1));
  assign allocNum = {1'b0, iALLOC_0_REQ} + {1'b0, iALLOC_1_REQ};
  assign cmtReq   = {1'b0, iCOMMIT_0_VALID} + {1'b0, iCOMMIT_1_VALID};
  assign freeReq  = {1'b0, iFREE_0_VALID} + {1'b0, iFREE_1_VALID};
  assign rdSpecP1 = rdSpec + PW'(1);
  assign wrP1     = wr + PW'(1);

  // Frees are packed: the first valid port lands at wr.
  assign firstName  = iFREE_0_VALID ? iFREE_0_REGNAME : iFREE_1_REGNAME;
  assign secondName = iFREE_1_REGNAME;

  assign grant = run & ~iRESTART_VALID & (allocNum != 2'd0)
               & (specCnt >= CW'(allocNum));

`ifdef RENAME_FREELIST_CHECK_EN
  logic [CW-1:0] outstanding;
  logic          freeOvf;
  logic          cmtOvf;
  logic          lowName;
  logic          errSet;
  logic          errReg;

  assign outstanding = cmtCnt - specCnt;
  assign freeOvf = (cmtCnt + CW'(freeReq)) > CW'(D);
  assign cmtOvf  = CW'(cmtReq) > outstanding;
  // Clamp value fits in 2 bits: it is below cmtReq.
  assign cmtNum  = cmtOvf ? outstanding[1:0] : cmtReq;
  assign freeNum = freeOvf ? 2'd0 : freeReq;
  assign lowName = (iFREE_0_VALID & (iFREE_0_REGNAME < 6'(LREG_NUM)))
                 | (iFREE_1_VALID & (iFREE_1_REGNAME < 6'(LREG_NUM)));
  assign errSet  = run & (freeOvf | cmtOvf | lowName);

  always_ff @(posedge iCLOCK) begin
    if (iRESET) begin
      errReg <= 1'b0;
    end else if (errSet) begin
      errReg <= 1'b1;
    end
  end

  assign oERROR = errReg;
`else
  assign cmtNum  = cmtReq;
  assign freeNum = freeReq;
  assign oERROR  = 1'b0;
`endif

  always_comb begin
    stateNext = state;
    unique case (state)
      INIT: if (initLast) stateNext = RUN;
      RUN:  stateNext = RUN;
      default: stateNext = INIT;
    endcase
  end

  always_ff @(posedge iCLOCK) begin
    if (iRESET) begin
      state   <= INIT;
      initCnt <= '0;
      rdSpec  <= '0;
      rdCmt   <= '0;
      wr      <= '0;
      specCnt <= '0;
      cmtCnt  <= '0;
    end else begin
      state <= stateNext;
      if (!run) begin
        initCnt <= initCnt + PW'(1);
        if (initLast) begin
          wr      <= '0;
          specCnt <= CW'(D);
          cmtCnt  <= CW'(D);
        end
      end else begin
        rdCmt  <= rdCmt + PW'(cmtNum);
        cmtCnt <= cmtCnt - CW'(cmtNum) + CW'(freeNum);
        wr     <= wr + PW'(freeNum);
        unique case (1'b1)
          iRESTART_VALID: begin
            rdSpec  <= rdCmt + PW'(cmtNum);
            specCnt <= cmtCnt - CW'(cmtNum) + CW'(freeNum);
          end
          grant: begin
            rdSpec  <= rdSpec + PW'(allocNum);
            specCnt <= specCnt - CW'(allocNum) + CW'(freeNum);
          end
          default: begin
            specCnt <= specCnt + CW'(freeNum);
          end
        endcase
      end
    end
  end

  // Storage has no reset; INIT rewrites every entry before use.
  always_ff @(posedge iCLOCK) begin
    if (!iRESET) begin
      if (!run) begin
        mem[initCnt] <= 6'(LREG_NUM) + 6'(initCnt);
      end else begin
        if (freeNum != 2'd0) mem[wr]   <= firstName;
        if (freeNum == 2'd2) mem[wrP1] <= secondName;
      end
    end
  end

  assign oALLOC_VALID     = grant;
  assign oALLOC_0_REGNAME = run ? mem[rdSpec] : 6'd0;
  assign oALLOC_1_REGNAME = !run        ? 6'd0
                          : iALLOC_0_REQ ? mem[rdSpecP1]
                          :                mem[rdSpec];
  assign oLOCK       = ~run | (specCnt < CW'(2));
  assign oFREE_COUNT = specCnt;
  assign oINIT_BUSY  = ~run;

endmodule

// File: tb/tb_rename_freelist_ctrl.sv
// Scoreboard bench for rename_freelist_ctrl: a queue-based model of the
// free list predicts each cycle's outputs; a negedge monitor compares them.

module tb_rename_freelist_ctrl;

  logic       iCLOCK = 1'b0;
  logic       iRESET = 1'b1;
  logic       iRESTART_VALID = 1'b0;
  logic       iALLOC_0_REQ = 1'b0;
  logic       iALLOC_1_REQ = 1'b0;
  logic       oALLOC_VALID;
  logic [5:0] oALLOC_0_REGNAME;
  logic [5:0] oALLOC_1_REGNAME;
  logic       iCOMMIT_0_VALID = 1'b0;
  logic       iCOMMIT_1_VALID = 1'b0;
  logic       iFREE_0_VALID = 1'b0;
  logic [5:0] iFREE_0_REGNAME = 6'd0;
  logic       iFREE_1_VALID = 1'b0;
  logic [5:0] iFREE_1_REGNAME = 6'd0;
  logic       oLOCK;
  logic [5:0] oFREE_COUNT;
  logic       oINIT_BUSY;
  logic       oERROR;

  rename_freelist_ctrl dut (
    .iCLOCK(iCLOCK),
    .iRESET(iRESET),
    .iRESTART_VALID(iRESTART_VALID),
    .iALLOC_0_REQ(iALLOC_0_REQ),
    .iALLOC_1_REQ(iALLOC_1_REQ),
    .oALLOC_VALID(oALLOC_VALID),
    .oALLOC_0_REGNAME(oALLOC_0_REGNAME),
    .oALLOC_1_REGNAME(oALLOC_1_REGNAME),
    .iCOMMIT_0_VALID(iCOMMIT_0_VALID),
    .iCOMMIT_1_VALID(iCOMMIT_1_VALID),
    .iFREE_0_VALID(iFREE_0_VALID),
    .iFREE_0_REGNAME(iFREE_0_REGNAME),
    .iFREE_1_VALID(iFREE_1_VALID),
    .iFREE_1_REGNAME(iFREE_1_REGNAME),
    .oLOCK(oLOCK),
    .oFREE_COUNT(oFREE_COUNT),
    .oINIT_BUSY(oINIT_BUSY),
    .oERROR(oERROR)
  );

  always #5 iCLOCK = ~iCLOCK;

  typedef struct {
    bit busy;
    bit lock;
    bit valid;
    bit err;
    int cnt;
    bit chk0;
    bit chk1;
    int n0;
    int n1;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  bit   endReq = 0;

  // Model: q holds list names oldest-first from the committed head;
  // the first outst of them are allocated but not yet committed.
  int q[$];
  int used[$];
  int outst;
  int initLeft;
  bit mErr;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge iCLOCK) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("busy", int'(oINIT_BUSY), int'(e.busy));
      chk("lock", int'(oLOCK), int'(e.lock));
      chk("valid", int'(oALLOC_VALID), int'(e.valid));
      chk("count", int'(oFREE_COUNT), e.cnt);
      chk("error", int'(oERROR), int'(e.err));
      if (e.chk0) chk("name0", int'(oALLOC_0_REGNAME), e.n0);
      if (e.chk1) chk("name1", int'(oALLOC_1_REGNAME), e.n1);
    end
    if (endReq) begin
      chk("drain", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
    end
  end

  task automatic step();
    exp_t e;
    int   n;
    int   c;
    int   cnt;
    int   fr[$];
    n = int'(iALLOC_0_REQ) + int'(iALLOC_1_REQ);
    c = int'(iCOMMIT_0_VALID) + int'(iCOMMIT_1_VALID);
    if (iFREE_0_VALID) fr.push_back(int'(iFREE_0_REGNAME));
    if (iFREE_1_VALID) fr.push_back(int'(iFREE_1_REGNAME));
    e.err = mErr;
    e.chk0 = 0;
    e.chk1 = 0;
    e.n0 = 0;
    e.n1 = 0;
    if (initLeft > 0) begin
      e.busy = 1;
      e.lock = 1;
      e.valid = 0;
      e.cnt = 0;
      e.chk0 = 1;
      e.chk1 = 1;
      initLeft--;
      if (initLeft == 0) begin
        for (int i = 0; i < 32; i++) q.push_back(32 + i);
        for (int i = 0; i < 32; i++) used.push_back(i);
        outst = 0;
      end
    end else begin
      cnt = q.size() - outst;
      e.busy = 0;
      e.cnt = cnt;
      e.lock = (cnt < 2);
      e.valid = !iRESTART_VALID && n != 0 && cnt >= n;
      if (cnt >= 1) begin
        e.chk0 = 1;
        e.n0 = q[outst];
      end
      if (iALLOC_0_REQ) begin
        if (cnt >= 2) begin
          e.chk1 = 1;
          e.n1 = q[outst + 1];
        end
      end else if (cnt >= 1) begin
        e.chk1 = 1;
        e.n1 = q[outst];
      end
`ifdef RENAME_FREELIST_CHECK_EN
      foreach (fr[i]) if (fr[i] < 32) mErr = 1;
      if (c > outst) begin
        c = outst;
        mErr = 1;
      end
      if (q.size() + fr.size() > 32) begin
        fr.delete();
        mErr = 1;
      end
`endif
      if (e.valid) outst += n;
      repeat (c) used.push_back(q.pop_front());
      outst -= c;
      foreach (fr[i]) q.push_back(fr[i]);
      if (iRESTART_VALID) outst = 0;
    end
    sb.push_back(e);
    @(posedge iCLOCK);
    #1;
  endtask

  task automatic cyc(input bit a0, input bit a1, input bit c0,
                     input bit c1, input bit rs,
                     input bit fv0, input int fn0,
                     input bit fv1, input int fn1);
    iALLOC_0_REQ = a0;
    iALLOC_1_REQ = a1;
    iCOMMIT_0_VALID = c0;
    iCOMMIT_1_VALID = c1;
    iRESTART_VALID = rs;
    iFREE_0_VALID = fv0;
    iFREE_0_REGNAME = 6'(fn0);
    iFREE_1_VALID = fv1;
    iFREE_1_REGNAME = 6'(fn1);
    step();
  endtask

  task automatic idle(input int k);
    repeat (k) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic doReset();
    iRESET = 1;
    iALLOC_0_REQ = 0;
    iALLOC_1_REQ = 0;
    iCOMMIT_0_VALID = 0;
    iCOMMIT_1_VALID = 0;
    iRESTART_VALID = 0;
    iFREE_0_VALID = 0;
    iFREE_1_VALID = 0;
    @(posedge iCLOCK);
    #1;
    @(posedge iCLOCK);
    #1;
    iRESET = 0;
    q.delete();
    used.delete();
    outst = 0;
    mErr = 0;
    initLeft = 32;
  endtask

  task automatic randPhase(input int k);
    bit a0, a1, c0, c1, rs, fv0, fv1;
    int fn0, fn1, idx, room;
    repeat (k) begin
      a0 = ($urandom % 4) != 0;
      a1 = ($urandom % 3) != 0;
      rs = ($urandom % 20) == 0;
      c0 = outst >= 1 && ($urandom % 2);
      c1 = c0 && outst >= 2 && ($urandom % 2);
      room = 32 - q.size();
      fv0 = room >= 1 && used.size() > 0 && ($urandom % 2);
      fn0 = 0;
      if (fv0) begin
        idx = $urandom_range(used.size() - 1);
        fn0 = used[idx];
        used.delete(idx);
      end
      fv1 = room >= int'(fv0) + 1 && used.size() > 0 && ($urandom % 2);
      fn1 = 0;
      if (fv1) begin
        idx = $urandom_range(used.size() - 1);
        fn1 = used[idx];
        used.delete(idx);
      end
      cyc(a0, a1, c0, c1, rs, fv0, fn0, fv1, fn1);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    outst = 0;
    mErr = 0;
    initLeft = 0;
    doReset();
    // reset release, INIT fill, then names 32/33 shown without a grant
    idle(32);
    cyc(1, 1, 0, 0, 1, 0, 0, 0, 0);
    // drain the whole list with dual allocs, then a refused request
    repeat (16) cyc(1, 1, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0, 0, 0);
    // make room, free 5 and 7, reuse them
    cyc(0, 0, 1, 1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 5, 1, 7);
    cyc(1, 1, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0, 0, 0, 0);
    // rollback: alloc 32..35, commit two, restart
    doReset();
    idle(32);
    cyc(1, 1, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 0, 0, 0);
    idle(1);
    // restart with same-cycle commit and free of 40
    cyc(1, 1, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 1, 1, 40, 0, 0);
    repeat (15) cyc(1, 1, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
`ifdef RENAME_FREELIST_CHECK_EN
    // overflowing free while full is dropped; error sticks until reset
    doReset();
    idle(32);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 33);
    idle(3);
    cyc(1, 1, 0, 0, 0, 0, 0, 0, 0);
    doReset();
    idle(2);
`endif
    doReset();
    idle(32);
    randPhase(1200);
    doReset();
    idle(32);
    randPhase(800);
    endReq = 1;
  end

endmodule
